// File: rtl/div_iterative.sv
// div_iterative: radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow in the issue cycle.
module div_iterative (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] first_operand_i,
  input  logic [31:0] second_operand_i,
  input  logic [1:0]  signed_mode_i,
  input  logic        enable_i,
  input  logic        rem_i,
  output logic        hold_o,
  output logic [31:0] result_o
);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t      r_state;
  logic [32:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_rem_sel;
  logic        r_a_neg;
  logic        r_b_neg;
  logic        r_div_zero;
  logic        w_a_neg;
  logic        w_b_neg;
  logic        w_b_zero;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [32:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res;
  assign w_a_neg  = signed_mode_i[0] & first_operand_i[31];
  assign w_b_neg  = signed_mode_i[1] & second_operand_i[31];
  assign w_b_zero = second_operand_i == 32'd0;
  assign w_a_abs  = w_a_neg ? -first_operand_i : first_operand_i;
  assign w_b_abs  = w_b_neg ? -second_operand_i : second_operand_i;
  // partial remainder stays below the divisor, so 34 bits hold the shifted value without overflow
  assign w_shift     = {r_rem, r_quot[31]};
  assign w_diff      = w_shift - {2'b00, r_div};
  assign w_ge        = ~w_diff[33];
  assign w_rem_next  = w_ge ? w_diff[32:0] : w_shift[32:0];
  assign w_quot_next = {r_quot[30:0], w_ge};
  assign w_q   = ((r_a_neg ^ r_b_neg) & ~r_div_zero) ? -w_quot_next : w_quot_next;
  assign w_r   = r_a_neg ? -w_rem_next[31:0] : w_rem_next[31:0];
  assign w_res = r_rem_sel ? w_r : w_q;
  assign hold_o = reset_n & enable_i & (r_state != DONE);
`ifdef DIV_EARLY_OUT_EN
  logic        w_ovf;
  logic [31:0] w_early_res;
  assign w_ovf = (&signed_mode_i) & (first_operand_i == 32'h8000_0000) & (&second_operand_i);
  assign w_early_res = w_b_zero ? (rem_i ? first_operand_i : 32'hFFFF_FFFF)
                                : (rem_i ? 32'd0 : 32'h8000_0000);
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      result_o   <= '0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_div      <= '0;
      r_rem_sel  <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (enable_i) begin
          r_rem_sel  <= rem_i;
          r_a_neg    <= w_a_neg;
          r_b_neg    <= w_b_neg;
          r_div_zero <= w_b_zero;
          r_quot     <= w_a_abs;
          r_div      <= w_b_abs;
          r_rem      <= '0;
          r_cnt      <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
          if (w_b_zero || w_ovf) begin
            r_state  <= DONE;
            result_o <= w_early_res;
          end else
`endif
          r_state <= DIVIDE;
        end
        DIVIDE: if (!enable_i) r_state <= IDLE;
        else begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) begin
            r_state  <= DONE;
            result_o <= w_res;
          end
        end
        DONE: if (!stall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
